result_reporter: RTL and testbench
==================================

RESULT_REPORTER -- requirements
Module: result_reporter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of result records buffered; power of two, 2..16.
REQ-002 SHALL have parameter HEADER, default 8'hA5: frame start byte.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_in  input  1  one-cycle hit strobe from the hasher's valid_out.
REQ-006 SHALL have port nonce_in  input  32  winning nonce, sampled when valid_in=1.
REQ-007 SHALL have port time_in  input  32  block time, sampled when valid_in=1.
REQ-008 SHALL have port result_in  input  256  final hash, sampled when valid_in=1.
REQ-009 SHALL have port tx_ready  input  1  host byte-sink ready.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_data  output  8  frame byte.
REQ-012 SHALL have port clr_overflow  input  1  synchronous clear of overflow and drop_count.
REQ-013 SHALL have port overflow  output  1  sticky flag: at least one record dropped.
REQ-014 SHALL have port drop_count  output  8  dropped records, saturating at 255.
REQ-015 SHALL have port pending  output  $clog2(DEPTH)+1  records in FIFO, excluding the frame in transmission.
REQ-016 SHALL have port busy  output  1  high while the FSM is outside IDLE.

Function
REQ-017 SHALL capture {nonce_in, time_in, result_in} as one 320-bit record into the FIFO on every edge where valid_in=1 and the FIFO is not full.
REQ-018 SHALL, when valid_in=1 and the FIFO is full with no pop on the same edge, drop the record, set overflow and increment drop_count (saturating at 255).
REQ-019 SHALL accept a push when full if a pop occurs on the same edge; overflow is not set.
REQ-020 SHALL implement FSM states IDLE, HDR, PAYLOAD and CSUM.
REQ-021 IDLE -> HDR when the FIFO is non-empty: pop the head record into a 320-bit shift register, clear the checksum and byte counter.
REQ-022 HDR: tx_data=HEADER; on tx_valid&&tx_ready -> PAYLOAD.
REQ-023 PAYLOAD: 40 bytes, MSB-first: nonce[31:24] first, then time, then result[255:248] through result[7:0].
REQ-024 PAYLOAD: each accepted byte is XORed into the checksum; after byte 40 is accepted -> CSUM.
REQ-025 CSUM: tx_data is the 8-bit XOR of the 40 payload bytes; on acceptance -> IDLE.
REQ-026 SHALL make the frame 42 bytes, and SHALL keep the 6-bit byte counter from wrapping.
REQ-027 tx_valid SHALL be 1 in HDR, PAYLOAD and CSUM, and 0 in IDLE.
REQ-028 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0; no byte is skipped or repeated.
REQ-029 Latency: with the FIFO empty and the FSM idle, valid_in at edge N SHALL produce tx_valid=1 with HEADER after edge N+2.
REQ-030 Back-to-back frames SHALL have exactly one IDLE cycle between CSUM acceptance and the next HDR.
REQ-031 clr_overflow=1 SHALL clear overflow and drop_count next edge; if a drop occurs on the same edge, the result SHALL be overflow=1, drop_count=1.
REQ-032 tx_ready SHALL be ignored in IDLE.

Reset
REQ-033 RST=0 SHALL immediately force: FSM=IDLE, FIFO empty, tx_valid=0, tx_data=0, overflow=0, drop_count=0, pending=0, busy=0.
REQ-034 Reset mid-frame SHALL abandon the frame and all queued records; after release, no partial frame is resumed.
REQ-035 After RST deasserts, the first edge SHALL be able to accept valid_in.

Structure
REQ-036 Package miner_pkg SHALL hold the HEADER default, the 320-bit record width constant, the frame length (42) and the FSM state enum.
REQ-037 The FIFO SHALL be a sub-module result_fifo (DEPTH, WIDTH params; push/pop/full/empty/count), with the FSM and serializer in result_reporter.

Verification
REQ-038 Single hit: nonce=32'h3aeb9bb8, time=32'h130dae51, result=256'h5C8AD782...2701000000000000, tx_ready=1 -> bytes A5,3A,EB,9B,B8,13,0D,AE,51,5C,8A,...,00 plus a checksum matching the model; HEADER at N+2.
REQ-039 Checksum: nonce=1, time=0, result=0 -> frame A5,00,00,00,01,(36 x 00),01.
REQ-040 Backpressure: tx_ready toggles pseudo-randomly -> identical 42-byte stream; tx_data stable while stalled.
REQ-041 Overflow: 6 hits on consecutive cycles with tx_ready=0, DEPTH=4 -> 1 frame in HDR, pending=4, overflow=1, drop_count=1; clr_overflow -> both 0.
REQ-042 Reset at payload byte 20 with 2 records queued -> tx_valid=0 immediately; pending=0; a new hit afterwards yields a complete fresh frame.
REQ-043 Push-when-full with simultaneous pop -> record accepted, overflow stays 0, all frames in order.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants and types for the mining result reporter.
// Holds the record layout, the frame geometry and the serializer FSM state type.
package miner_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned REC_W          = 320;
  localparam int unsigned FRAME_LEN      = 42;
  localparam int unsigned PAYLOAD_LEN    = FRAME_LEN - 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHdr     = 2'd1,
    StPayload = 2'd2,
    StCsum    = 2'd3
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for result records; a push into a full FIFO is taken only
// when a pop happens on the same edge.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 320
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne  = 1;
  localparam logic [AW:0]   CntFull = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/result_reporter.sv
// Buffers hasher hits and streams each as a 42-byte frame:
// header, 40 payload bytes (nonce, time, result, MSB first), XOR checksum.
module result_reporter
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   valid_in,
  input  logic [31:0]            nonce_in,
  input  logic [31:0]            time_in,
  input  logic [255:0]           result_in,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   clr_overflow,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   busy
);

  localparam logic [5:0] LastByte = 6'(PAYLOAD_LEN - 1);

  state_e           state_q, state_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [7:0]       csum_q, csum_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             start_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [REC_W-1:0]       fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   drop, accept;

  assign accept   = tx_valid & tx_ready;
  // A new record sits one cycle in the FIFO before the idle FSM may pop it.
  assign fifo_pop = (state_q == StIdle) & start_q & ~fifo_empty;
  assign drop     = valid_in & fifo_full & ~fifo_pop;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (valid_in),
    .wdata ({nonce_in, time_in, result_in}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fifo_pop) begin
          shreg_d = fifo_rdata;
          csum_d  = '0;
          cnt_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (accept) state_d = StPayload;
      end
      StPayload: begin
        if (accept) begin
          csum_d  = csum_q ^ shreg_q[REC_W-1 -: 8];
          shreg_d = {shreg_q[REC_W-9:0], 8'h00};
          if (cnt_q == LastByte) state_d = StCsum;
          else                   cnt_d   = cnt_q + 6'd1;
        end
      end
      StCsum: begin
        if (accept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr_overflow) begin
      overflow_d = drop;
      drop_d     = {7'd0, drop};
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      start_q    <= ~fifo_empty;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    tx_valid = (state_q != StIdle);
    unique case (state_q)
      StHdr:     tx_data = HEADER;
      StPayload: tx_data = shreg_q[REC_W-1 -: 8];
      StCsum:    tx_data = csum_q;
      default:   tx_data = 8'h00;
    endcase
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign pending    = fifo_count;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_result_reporter.sv
// Self-checking bench for result_reporter: frames are predicted from the
// record fields, and received bytes are compared in order.
module tb_result_reporter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         valid_in = 1'b0;
  logic [31:0]  nonce_in = '0;
  logic [31:0]  time_in = '0;
  logic [255:0] result_in = '0;
  logic         tx_ready = 1'b0;
  logic         clr_overflow = 1'b0;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         overflow;
  logic [7:0]   drop_count;
  logic [2:0]   pending;
  logic         busy;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  result_reporter #(
    .DEPTH  (4),
    .HEADER (8'hA5)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .valid_in     (valid_in),
    .nonce_in     (nonce_in),
    .time_in      (time_in),
    .result_in    (result_in),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .clr_overflow (clr_overflow),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .pending      (pending),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  // Reference frame: header, nonce/time/result bytes MSB first, XOR of payload.
  task automatic model_frame(input logic [31:0] n, input logic [31:0] t,
                             input logic [255:0] r);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = n[31-8*i -: 8]; cs ^= b; exp_q.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      b = t[31-8*i -: 8]; cs ^= b; exp_q.push_back(b);
    end
    for (int i = 0; i < 32; i++) begin
      b = r[255-8*i -: 8]; cs ^= b; exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    if (tx_valid === 1'b1 && tx_ready === 1'b1) rx_q.push_back(tx_data);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) tick();
  endtask

  task automatic set_hit(input logic [31:0] n, input logic [31:0] t, input logic [255:0] r);
    valid_in = 1'b1; nonce_in = n; time_in = t; result_in = r;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    valid_in = 1'b0; tx_ready = 1'b0; clr_overflow = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b0;
    #1;
    total += 6;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending: got %0d want 0", pending); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    rx_q.delete();
    exp_q.delete();
  endtask

  // Hit on the first edge after reset release; also checks header latency.
  task automatic test_single_hit();
    logic [255:0] r;
    r = 256'h5C8AD782_1F3E44A9_C0FFEE00_DEADBEEF_0BADF00D_12345678_27010000_00000000;
    tx_ready = 1'b1;
    set_hit(32'h3aeb9bb8, 32'h130dae51, r);
    model_frame(32'h3aeb9bb8, 32'h130dae51, r);
    tick();
    valid_in = 1'b0;
    total += 2;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL lat_n0: tx_valid=%b want 0", tx_valid); end
    if (pending !== 3'd1) begin bad++; $display("FAIL lat_pending: got %0d want 1", pending); end
    tick();
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL lat_n1: tx_valid=%b want 0", tx_valid); end
    tick();
    total += 2;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL lat_n2_valid: got %b want 1", tx_valid); end
    if (tx_data !== 8'hA5) begin bad++; $display("FAIL lat_n2_hdr: got %h want a5", tx_data); end
    wait_bytes(42, 200);
    total++;
    if (rx_q.size() != 42) begin bad++; $display("FAIL single_len: got %0d want 42", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 42; i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (3) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_checksum();
    logic [7:0] fr [42];
    do_reset();
    for (int i = 0; i < 42; i++) fr[i] = 8'h00;
    fr[0] = 8'hA5; fr[4] = 8'h01; fr[41] = 8'h01;
    tx_ready = 1'b1;
    set_hit(32'd1, 32'd0, 256'd0);
    tick();
    valid_in = 1'b0;
    wait_bytes(42, 200);
    total++;
    if (rx_q.size() != 42) begin bad++; $display("FAIL csum_len: got %0d want 42", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 42; i++) begin
      total++;
      if (rx_q[i] !== fr[i]) begin
        bad++; $display("FAIL csum_byte%0d: got %h want %h", i, rx_q[i], fr[i]);
      end
    end
  endtask

  // Random hits with random tx_ready; held bytes must not change while stalled.
  task automatic test_backpressure();
    logic       stalled;
    logic [7:0] held;
    logic [31:0] n, t;
    int hits_left;
    int gap;
    do_reset();
    stalled = 1'b0;
    held = 8'h00;
    for (int round = 0; round < 3; round++) begin
      hits_left = 1 + int'($urandom % 4);
      gap = int'($urandom % 4);
      for (int c = 0; c < 3000 && (hits_left > 0 || rx_q.size() < exp_q.size()); c++) begin
        tx_ready = 1'($urandom % 2);
        if (hits_left > 0 && gap == 0) begin
          n = $urandom; t = $urandom;
          set_hit(n, t, rand256());
          model_frame(n, t, result_in);
          hits_left--;
          gap = int'($urandom % 6);
        end else begin
          valid_in = 1'b0;
          if (gap > 0) gap--;
        end
        @(negedge CLK);
        if (stalled) begin
          total++;
          if (tx_valid !== 1'b1 || tx_data !== held) begin
            bad++;
            $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h", tx_valid, tx_data,
                     held);
          end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) rx_q.push_back(tx_data);
        stalled = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
        held = tx_data;
        @(posedge CLK);
        #1;
      end
      valid_in = 1'b0;
    end
    total += 2;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", overflow); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] n, t;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n = $urandom; t = $urandom;
      set_hit(n, t, rand256());
      if (i < 5) model_frame(n, t, result_in);
      tick();
    end
    valid_in = 1'b0;
    tick();
    total += 5;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL ovf_hdr: valid=%b data=%h want 1/a5", tx_valid, tx_data);
    end
    if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy: got %b want 1", busy); end
    if (pending !== 3'd4) begin bad++; $display("FAIL ovf_pending: got %0d want 4", pending); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop: got %0d want 1", drop_count); end
    set_hit($urandom, $urandom, rand256());
    clr_overflow = 1'b1;
    tick();
    valid_in = 1'b0;
    clr_overflow = 1'b0;
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL clr_drop_flag: got %b want 1", overflow); end
    if (drop_count !== 8'd1) begin
      bad++; $display("FAIL clr_drop_cnt: got %0d want 1", drop_count);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clr_flag: got %b want 0", overflow); end
    if (drop_count !== 8'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", drop_count); end
    for (int i = 0; i < 260; i++) begin
      set_hit($urandom, $urandom, rand256());
      tick();
    end
    valid_in = 1'b0;
    total++;
    if (drop_count !== 8'd255) begin
      bad++; $display("FAIL drop_sat: got %0d want 255", drop_count);
    end
    tx_ready = 1'b1;
    wait_bytes(exp_q.size(), 1000);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ovf_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] n, t;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_hit($urandom, $urandom, rand256());
      tick();
    end
    valid_in = 1'b0;
    tick();
    tx_ready = 1'b1;
    wait_bytes(21, 200);
    RST = 1'b0;
    #1;
    total += 3;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
    if (pending !== 3'd0) begin bad++; $display("FAIL mid_pending: got %0d want 0", pending); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    rx_q.delete();
    exp_q.delete();
    n = $urandom; t = $urandom;
    set_hit(n, t, rand256());
    model_frame(n, t, result_in);
    tick();
    valid_in = 1'b0;
    wait_bytes(42, 200);
    repeat (60) tick();
    total++;
    if (rx_q.size() != 42) begin bad++; $display("FAIL mid_len: got %0d want 42", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 42; i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL mid_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  // Push lands on the very edge where the idle FSM pops from a full FIFO.
  task automatic test_push_pop_full();
    logic [31:0] n, t;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = $urandom; t = $urandom;
      set_hit(n, t, rand256());
      model_frame(n, t, result_in);
      tick();
    end
    valid_in = 1'b0;
    tick();
    total++;
    if (pending !== 3'd4) begin bad++; $display("FAIL ppf_full: got %0d want 4", pending); end
    tx_ready = 1'b1;
    wait_bytes(42, 200);
    n = $urandom; t = $urandom;
    set_hit(n, t, rand256());
    model_frame(n, t, result_in);
    tick();
    valid_in = 1'b0;
    total += 3;
    if (pending !== 3'd4) begin bad++; $display("FAIL ppf_pending: got %0d want 4", pending); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL ppf_overflow: got %b want 0", overflow); end
    if (drop_count !== 8'd0) begin bad++; $display("FAIL ppf_drop: got %0d want 0", drop_count); end
    wait_bytes(exp_q.size(), 1000);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ppf_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ppf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_checksum();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_push_pop_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
